// File: rtl/wash_phase_timer_if.sv
// Control bundle between the washing-machine FSM (master) and the phase timer (slave).
// Handshake: the master holds timer_enable high for as long as it wants phases timed; the slave
// answers each expired phase with a one-cycle timer_done, and dropping timer_enable aborts at once.
interface wash_phase_timer_if #(
  parameter int CNT_W = 12
);
  logic             timer_enable;
  logic [1:0]       phase_sel;
  logic             mode1;
  logic             mode2;
  logic             mode3;
  logic             pause;
  logic             timer_done;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output timer_enable, phase_sel, mode1, mode2, mode3, pause,
    input  timer_done, remaining, busy, dbg_state
  );

  modport slave (
    input  timer_enable, phase_sel, mode1, mode2, mode3, pause,
    output timer_done, remaining, busy, dbg_state
  );
endinterface

// File: rtl/wash_phase_timer.sv
// Phase-duration timer: mode-scaled per-phase duration counted down in prescaled seconds.
// dbg_state encodes IDLE=0, LOAD=1, RUN=2, DONE=3.
module wash_phase_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 12,
  parameter int SOAK_T   = 600,
  parameter int WASH_T   = 900,
  parameter int RINSE_T  = 300,
  parameter int SPIN_T   = 300
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wash_phase_timer_if.slave     bus
);
  localparam int          PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [31:0] MAX_CNT = (32'd1 << CNT_W) - 32'd1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_presc;
  logic [CNT_W-1:0] r_remaining;
  logic             r_done;
  logic             r_busy;
  logic [1:0]       r_phase_q;

  state_t           w_next;
  logic [PRE_W-1:0] w_presc_nx;
  logic [CNT_W-1:0] w_rem_nx;
  logic             w_done_nx;
  logic [1:0]       w_phase_nx;
  logic [31:0]      w_base;
  logic [31:0]      w_scaled;
  logic [CNT_W-1:0] w_dur;

  // Duration from the live selects; only consumed on the LOAD exit edge.
  always_comb begin
    w_base = 32'(SOAK_T);
    case (bus.phase_sel)
      2'b00: w_base = 32'(SOAK_T);
      2'b01: w_base = 32'(WASH_T);
      2'b10: w_base = 32'(RINSE_T);
      default: w_base = 32'(SPIN_T);
    endcase
    if (bus.mode1 || !(bus.mode2 || bus.mode3)) begin
      w_scaled = w_base;
    end else if (bus.mode2) begin
      w_scaled = w_base << 1;
    end else begin
      w_scaled = w_base >> 1;
    end
    if (w_scaled > MAX_CNT) begin
      w_scaled = MAX_CNT;
    end
    w_dur = (w_scaled == 32'd0) ? CNT_W'(1) : w_scaled[CNT_W-1:0];
  end

  always_comb begin
    w_next     = r_state;
    w_presc_nx = r_presc;
    w_rem_nx   = r_remaining;
    w_done_nx  = 1'b0;
    w_phase_nx = r_phase_q;
    if (!bus.timer_enable) begin
      w_next     = S_IDLE;
      w_presc_nx = '0;
      w_rem_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next = S_LOAD;
        end
        S_LOAD: begin
          w_next     = S_RUN;
          w_phase_nx = bus.phase_sel;
          w_rem_nx   = w_dur;
          w_presc_nx = '0;
        end
        S_RUN: begin
          if (!bus.pause) begin
            if (r_presc == PRE_LAST && r_remaining == CNT_W'(1)) begin
              w_next     = S_DONE;
              w_done_nx  = 1'b1;
              w_presc_nx = '0;
              w_rem_nx   = '0;
            end else if (bus.phase_sel != r_phase_q) begin
              w_next = S_LOAD;
            end else if (r_presc == PRE_LAST) begin
              w_presc_nx = '0;
              w_rem_nx   = r_remaining - CNT_W'(1);
            end else begin
              w_presc_nx = r_presc + PRE_W'(1);
            end
          end
        end
        default: begin
          w_next   = S_LOAD;
          w_rem_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_phase_q   <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_presc     <= w_presc_nx;
      r_remaining <= w_rem_nx;
      r_done      <= w_done_nx;
      r_busy      <= (w_next != S_IDLE);
      r_phase_q   <= w_phase_nx;
    end
  end

  assign bus.timer_done = r_done;
  assign bus.remaining  = r_remaining;
  assign bus.busy       = r_busy;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with small durations; edge counts are relative to e0,
// the edge at which timer_enable is first sampled high in IDLE.
module tb_wash_phase_timer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   edge_cnt;
  int   e0;
  int   at;
  int   d;
  int   pulses;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  wash_phase_timer_if #(.CNT_W(8)) tif ();
  wash_phase_timer_if #(.CNT_W(8)) tif_s ();

  wash_phase_timer #(
    .TICK_DIV(4), .CNT_W(8), .SOAK_T(3), .WASH_T(5), .RINSE_T(2), .SPIN_T(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(tif)
  );

  wash_phase_timer #(
    .TICK_DIV(4), .CNT_W(8), .SOAK_T(3), .WASH_T(200), .RINSE_T(2), .SPIN_T(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(tif_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_cnt++;
    end
  endtask

  task automatic start(input logic [1:0] ph, input logic m1, input logic m2, input logic m3);
    tif.phase_sel    = ph;
    tif.mode1        = m1;
    tif.mode2        = m2;
    tif.mode3        = m3;
    tif.pause        = 1'b0;
    tif.timer_enable = 1'b1;
    step(1);
    e0 = edge_cnt;
  endtask

  task automatic stop();
    tif.timer_enable = 1'b0;
    tif.pause        = 1'b0;
    step(1);
  endtask

  task automatic wait_done(input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (tif.timer_done === 1'b1) begin
        when = edge_cnt;
        break;
      end
    end
    if (when < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; edge_cnt = 0; e0 = 0;
    rst_n = 1'b0;
    tif.timer_enable = 1'b0; tif.phase_sel = 2'b00; tif.pause = 1'b0;
    tif.mode1 = 1'b0; tif.mode2 = 1'b0; tif.mode3 = 1'b0;
    tif_s.timer_enable = 1'b0; tif_s.phase_sel = 2'b00; tif_s.pause = 1'b0;
    tif_s.mode1 = 1'b0; tif_s.mode2 = 1'b0; tif_s.mode3 = 1'b0;
    step(2);
    check("rst_remaining", 32'(tif.remaining), 32'd0);
    check("rst_done", 32'(tif.timer_done), 32'd0);
    check("rst_busy", 32'(tif.busy), 32'd0);
    check("rst_state", 32'(tif.dbg_state), 32'd0);
    rst_n = 1'b1;
    step(1);

    // mode1 soak: 3,2,1 at 4-cycle intervals, done at e0+13
    exp_q.push_back(32'd3); exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    start(2'b00, 1'b1, 1'b0, 1'b0);
    check("t1_busy_load", 32'(tif.busy), 32'd1);
    check("t1_state_load", 32'(tif.dbg_state), 32'd1);
    step(1);
    exp_v = exp_q.pop_front();
    check("t1_rem_a", 32'(tif.remaining), exp_v);
    step(3);
    check("t1_rem_hold", 32'(tif.remaining), 32'd3);
    step(1);
    exp_v = exp_q.pop_front();
    check("t1_rem_b", 32'(tif.remaining), exp_v);
    step(4);
    exp_v = exp_q.pop_front();
    check("t1_rem_c", 32'(tif.remaining), exp_v);
    check("t1_no_early_done", 32'(tif.timer_done), 32'd0);
    step(4);
    check("t1_done_edge", 32'(edge_cnt - e0), 32'd13);
    check("t1_done", 32'(tif.timer_done), 32'd1);
    check("t1_rem_done", 32'(tif.remaining), 32'd0);
    stop();
    check("t1_done_single", 32'(tif.timer_done), 32'd0);
    check("t1_idle_busy", 32'(tif.busy), 32'd0);

    // mode scaling
    start(2'b01, 1'b0, 1'b1, 1'b0);
    wait_done(100, at);
    check("t2_heavy_wash", 32'(at - e0), 32'd41);
    stop();
    start(2'b10, 1'b0, 1'b0, 1'b1);
    wait_done(100, at);
    check("t2_quick_rinse", 32'(at - e0), 32'd5);
    stop();
    start(2'b00, 1'b1, 1'b0, 1'b1);
    step(1);
    check("t2_prio_rem", 32'(tif.remaining), 32'd3);
    wait_done(100, at);
    check("t2_prio_soak", 32'(at - e0), 32'd13);
    stop();
    start(2'b11, 1'b0, 1'b0, 1'b0);
    wait_done(100, at);
    check("t2_nomode_spin", 32'(at - e0), 32'd17);
    stop();

    // saturation on the second instance (WASH_T=200, heavy)
    tif_s.phase_sel = 2'b01; tif_s.mode2 = 1'b1; tif_s.timer_enable = 1'b1;
    step(2);
    check("t2_sat_rem", 32'(tif_s.remaining), 32'd255);
    tif_s.timer_enable = 1'b0;
    step(1);
    check("t2_sat_abort", 32'(tif_s.remaining), 32'd0);

    // pause for 6 RUN cycles
    start(2'b00, 1'b1, 1'b0, 1'b0);
    step(6);
    tif.pause = 1'b1;
    step(3);
    check("t3_rem_paused_a", 32'(tif.remaining), 32'd2);
    step(3);
    check("t3_rem_paused_b", 32'(tif.remaining), 32'd2);
    check("t3_state_paused", 32'(tif.dbg_state), 32'd2);
    tif.pause = 1'b0;
    wait_done(100, at);
    check("t3_pause_done", 32'(at - e0), 32'd19);
    step(1);
    check("t3_done_single", 32'(tif.timer_done), 32'd0);
    stop();

    // back-to-back phases with timer_enable held
    start(2'b00, 1'b1, 1'b0, 1'b0);
    wait_done(100, d);
    check("t4_first_done", 32'(d - e0), 32'd13);
    step(1);
    check("t4_auto_load", 32'(tif.dbg_state), 32'd1);
    tif.phase_sel = 2'b01;
    step(1);
    check("t4_wash_rem", 32'(tif.remaining), 32'd5);
    wait_done(100, at);
    check("t4_second_done", 32'(at - d), 32'd22);
    stop();

    // abort mid-RUN
    start(2'b00, 1'b1, 1'b0, 1'b0);
    step(6);
    tif.timer_enable = 1'b0;
    step(1);
    check("t5_abort_state", 32'(tif.dbg_state), 32'd0);
    check("t5_abort_rem", 32'(tif.remaining), 32'd0);
    check("t5_abort_busy", 32'(tif.busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (tif.timer_done === 1'b1) pulses++;
      step(1);
    end
    check("t5_abort_no_pulse", 32'(pulses), 32'd0);

    // phase change mid-RUN restarts with spin
    start(2'b00, 1'b1, 1'b0, 1'b0);
    step(6);
    tif.phase_sel = 2'b11;
    step(1);
    check("t5_chg_load", 32'(tif.dbg_state), 32'd1);
    check("t5_chg_rem_hold", 32'(tif.remaining), 32'd2);
    step(1);
    check("t5_chg_rem", 32'(tif.remaining), 32'd4);
    wait_done(100, at);
    check("t5_chg_done", 32'(at - e0), 32'd24);
    stop();

    // reset mid-RUN with timer_enable held
    start(2'b00, 1'b1, 1'b0, 1'b0);
    step(6);
    rst_n = 1'b0;
    step(1);
    check("t6_rst_rem", 32'(tif.remaining), 32'd0);
    check("t6_rst_busy", 32'(tif.busy), 32'd0);
    check("t6_rst_done", 32'(tif.timer_done), 32'd0);
    check("t6_rst_state", 32'(tif.dbg_state), 32'd0);
    rst_n = 1'b1;
    step(1);
    check("t6_reload_state", 32'(tif.dbg_state), 32'd1);
    e0 = edge_cnt;
    wait_done(100, at);
    check("t6_recount_done", 32'(at - e0), 32'd13);
    stop();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
